// File: rtl/lcd_read_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_read_ctrl
// Read-cycle engine for an HD44780-style 16x2 character LCD. It issues RW=1
// bus cycles that return either the busy flag / address counter (RS=0) or a
// DDRAM/CGRAM data byte (RS=1). In optional busy-poll mode it repeats status
// reads until BF=0, or gives up after MAX_POLLS pulses.
//
// Ports
//   CLK_50M      system clock, 50 MHz
//   rst_n        asynchronous active-low reset
//   req          start request, sampled in IDLE only
//   rs_sel       0 = status read, 1 = data read (captured with req)
//   poll         repeat status reads until BF=0 (captured with req, ignored for data reads)
//   LCD_DATA_IN  panel data bus as seen by the pad
//   LCD_RS       register select to panel
//   LCD_RW       1 = read
//   LCD_EN       enable strobe
//   rd_active    high while this block owns the bus (arbiter releases LCD_DATA)
//   ready        high in IDLE only
//   done         one-cycle completion pulse
//   rd_data      last sampled byte
//   busy_flag    bit 7 of the last status read
//   addr_cnt     bits 6:0 of the last status read
//   poll_count   EN pulses issued by the last operation (saturating)
//   timeout      poll gave up with BF still set; held until the next req
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for req, ready=1
// S_SETUP | RS/RW stable, EN low, T_AS clocks of address setup
// S_EN_HI | EN high for T_PW clocks, bus sampled on the last one
// S_HOLD  | EN low for T_H clocks, then re-poll or finish
// S_DONE  | single-cycle done pulse, bus handed back
// -----------------------------------------------------------------------------
module lcd_read_ctrl #(
  parameter int T_AS      = 3,
  parameter int T_PW      = 25,
  parameter int T_H       = 25,
  parameter int MAX_POLLS = 2000,
  parameter int POLL_W    = 12
) (
  input  logic              CLK_50M,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rs_sel,
  input  logic              poll,
  input  logic [7:0]        LCD_DATA_IN,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic              LCD_EN,
  output logic              rd_active,
  output logic              ready,
  output logic              done,
  output logic [7:0]        rd_data,
  output logic              busy_flag,
  output logic [6:0]        addr_cnt,
  output logic [POLL_W-1:0] poll_count,
  output logic              timeout
);

  localparam int CNT_MAX = (T_AS > T_PW) ? ((T_AS > T_H) ? T_AS : T_H)
                                         : ((T_PW > T_H) ? T_PW : T_H);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  LD_AS   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0]  LD_PW   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0]  LD_H    = CNT_W'(T_H - 1);
  localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(MAX_POLLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rs_sel_q, rs_sel_d;
  logic                poll_q, poll_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                busy_flag_q, busy_flag_d;
  logic [6:0]          addr_cnt_q, addr_cnt_d;
  logic [POLL_W-1:0]   poll_count_q, poll_count_d;
  logic                timeout_q, timeout_d;

  logic                lcd_rs_q, lcd_rs_d;
  logic                lcd_rw_q, lcd_rw_d;
  logic                lcd_en_q, lcd_en_d;
  logic                rd_active_q, rd_active_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rs_sel_d     = rs_sel_q;
    poll_d       = poll_q;
    rd_data_d    = rd_data_q;
    busy_flag_d  = busy_flag_q;
    addr_cnt_d   = addr_cnt_q;
    poll_count_d = poll_count_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          rs_sel_d     = rs_sel;
          poll_d       = poll;
          poll_count_d = '0;
          timeout_d    = 1'b0;
          cnt_d        = LD_AS;
          state_d      = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = LD_PW;
          state_d = S_EN_HI;
          if (poll_count_q != POLL_LIM) begin
            poll_count_d = poll_count_q + POLL_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_EN_HI: begin
        if (cnt_q == '0) begin
          rd_data_d = LCD_DATA_IN;
          // Only a status read refreshes BF/AC; data reads leave them intact.
          if (!rs_sel_q) begin
            busy_flag_d = LCD_DATA_IN[7];
            addr_cnt_d  = LCD_DATA_IN[6:0];
          end
          cnt_d   = LD_H;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d = '0;
          if (poll_q && !rs_sel_q && busy_flag_q) begin
            if (poll_count_q < POLL_LIM) begin
              cnt_d   = LD_AS;
              state_d = S_SETUP;
            end else begin
              timeout_d = 1'b1;
              state_d   = S_DONE;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus outputs are decoded from the next state so they are registered
    // and line up exactly with the state they describe.
    lcd_rw_d    = (state_d == S_SETUP) || (state_d == S_EN_HI) || (state_d == S_HOLD);
    lcd_rs_d    = lcd_rw_d && rs_sel_d;
    lcd_en_d    = (state_d == S_EN_HI);
    rd_active_d = lcd_rw_d;
    ready_d     = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rs_sel_q     <= 1'b0;
      poll_q       <= 1'b0;
      rd_data_q    <= '0;
      busy_flag_q  <= 1'b0;
      addr_cnt_q   <= '0;
      poll_count_q <= '0;
      timeout_q    <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_rw_q     <= 1'b0;
      lcd_en_q     <= 1'b0;
      rd_active_q  <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rs_sel_q     <= rs_sel_d;
      poll_q       <= poll_d;
      rd_data_q    <= rd_data_d;
      busy_flag_q  <= busy_flag_d;
      addr_cnt_q   <= addr_cnt_d;
      poll_count_q <= poll_count_d;
      timeout_q    <= timeout_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_rw_q     <= lcd_rw_d;
      lcd_en_q     <= lcd_en_d;
      rd_active_q  <= rd_active_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
    end
  end

  assign LCD_RS     = lcd_rs_q;
  assign LCD_RW     = lcd_rw_q;
  assign LCD_EN     = lcd_en_q;
  assign rd_active  = rd_active_q;
  assign ready      = ready_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;
  assign busy_flag  = busy_flag_q;
  assign addr_cnt   = addr_cnt_q;
  assign poll_count = poll_count_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_read_ctrl
// Bench for lcd_read_ctrl. A small panel model answers each EN pulse from a
// per-operation response list; the expected outcome of each operation (pulse
// count, timing, final registers, timeout) is derived from that list.
// -----------------------------------------------------------------------------
module tb_lcd_read_ctrl;

  localparam int T_AS      = 3;
  localparam int T_PW      = 25;
  localparam int T_H       = 25;
  localparam int MAX_POLLS = 8;
  localparam int POLL_W    = 12;
  localparam int CYC       = T_AS + T_PW + T_H;

  logic              CLK_50M = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              rs_sel = 1'b0;
  logic              poll = 1'b0;
  logic [7:0]        LCD_DATA_IN = 8'h00;
  logic              LCD_RS, LCD_RW, LCD_EN, rd_active, ready, done;
  logic [7:0]        rd_data;
  logic              busy_flag;
  logic [6:0]        addr_cnt;
  logic [POLL_W-1:0] poll_count;
  logic              timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] resp [16];
  logic [7:0] m_rd_data = 8'h00;
  logic       m_bf      = 1'b0;
  logic [6:0] m_ac      = 7'h00;

  lcd_read_ctrl #(
    .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .MAX_POLLS(MAX_POLLS), .POLL_W(POLL_W)
  ) dut (
    .CLK_50M(CLK_50M), .rst_n(rst_n), .req(req), .rs_sel(rs_sel), .poll(poll),
    .LCD_DATA_IN(LCD_DATA_IN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .rd_active(rd_active), .ready(ready), .done(done), .rd_data(rd_data),
    .busy_flag(busy_flag), .addr_cnt(addr_cnt), .poll_count(poll_count),
    .timeout(timeout)
  );

  always #10 CLK_50M = ~CLK_50M;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one operation from the response list alone.
  task automatic model_op(input logic rs, input logic pl, output int pulses, output logic tmo);
    bit found;
    found  = 1'b0;
    pulses = 1;
    tmo    = 1'b0;
    if (!rs && pl) begin
      for (int i = 0; i < MAX_POLLS; i++) begin
        if (!found) begin
          pulses = i + 1;
          if (!resp[i][7]) found = 1'b1;
        end
      end
      tmo = !found;
    end
    m_rd_data = resp[pulses-1];
    if (!rs) begin
      m_bf = resp[pulses-1][7];
      m_ac = resp[pulses-1][6:0];
    end
  endtask

  task automatic run_op(input string name, input logic rs, input logic pl, input bit extra_req);
    int   exp_pulses;
    logic exp_tmo;
    int   exp_done;
    int   pulses = 0, en_len = 0, last_rise = 0, done_cyc = -1, done_cnt = 0;
    bit   width_bad = 0, space_bad = 0, rw_bad = 0, rs_bad = 0, act_bad = 0, post_bad = 0;
    logic prev_en = 1'b0;

    model_op(rs, pl, exp_pulses, exp_tmo);
    exp_done = 1 + T_AS + T_PW + T_H + CYC * (exp_pulses - 1);

    @(negedge CLK_50M);
    check_val({name, ".ready_idle"}, ready, 1);
    rs_sel = rs;
    poll   = pl;
    req    = 1'b1;
    @(posedge CLK_50M);
    @(negedge CLK_50M);
    req    = 1'b0;
    rs_sel = 1'($urandom);
    poll   = 1'($urandom);

    for (int cyc = 1; cyc <= exp_done + 12; cyc++) begin
      if (extra_req) req = (cyc == 10);
      if (LCD_EN && !prev_en) begin
        pulses++;
        if (pulses == 1) begin
          if (cyc != T_AS + 1) space_bad = 1;
        end else if (cyc - last_rise != CYC) begin
          space_bad = 1;
        end
        last_rise   = cyc;
        LCD_DATA_IN = resp[(pulses-1) & 15];
        en_len      = 0;
      end
      if (LCD_EN) en_len++;
      if (!LCD_EN && prev_en && en_len != T_PW) width_bad = 1;
      if (LCD_EN && !LCD_RW) rw_bad = 1;
      if (rd_active != LCD_RW) rw_bad = 1;
      if (rd_active && LCD_RS != rs) rs_bad = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (LCD_RW || LCD_RS || rd_active || ready) rw_bad = 1;
      end else if (done_cnt == 0) begin
        if (ready || !rd_active) act_bad = 1;
      end else begin
        if (!ready || rd_active || LCD_EN) post_bad = 1;
      end
      prev_en = LCD_EN;
      @(negedge CLK_50M);
    end
    req = 1'b0;

    check_val({name, ".pulses"},     pulses,     exp_pulses);
    check_val({name, ".done_cnt"},   done_cnt,   1);
    check_val({name, ".done_cyc"},   done_cyc,   exp_done);
    check_val({name, ".en_width"},   width_bad,  0);
    check_val({name, ".en_spacing"}, space_bad,  0);
    check_val({name, ".rw_bus"},     rw_bad,     0);
    check_val({name, ".rs_bus"},     rs_bad,     0);
    check_val({name, ".active"},     act_bad,    0);
    check_val({name, ".after_done"}, post_bad,   0);
    check_val({name, ".rd_data"},    rd_data,    m_rd_data);
    check_val({name, ".busy_flag"},  busy_flag,  m_bf);
    check_val({name, ".addr_cnt"},   addr_cnt,   m_ac);
    check_val({name, ".poll_count"}, poll_count, exp_pulses);
    check_val({name, ".timeout"},    timeout,    exp_tmo);
  endtask

  task automatic check_reset_vals(input string name);
    check_val({name, ".en"},         LCD_EN,     0);
    check_val({name, ".rw"},         LCD_RW,     0);
    check_val({name, ".rs"},         LCD_RS,     0);
    check_val({name, ".rd_active"},  rd_active,  0);
    check_val({name, ".ready"},      ready,      1);
    check_val({name, ".done"},       done,       0);
    check_val({name, ".rd_data"},    rd_data,    0);
    check_val({name, ".busy_flag"},  busy_flag,  0);
    check_val({name, ".addr_cnt"},   addr_cnt,   0);
    check_val({name, ".poll_count"}, poll_count, 0);
    check_val({name, ".timeout"},    timeout,    0);
  endtask

  task automatic reset_mid_en();
    resp[0] = 8'h33;
    @(negedge CLK_50M);
    rs_sel = 1'b0;
    poll   = 1'b0;
    req    = 1'b1;
    @(posedge CLK_50M);
    @(negedge CLK_50M);
    req = 1'b0;
    // Now in cycle 1 after the request edge; EN occupies cycles 4..28.
    repeat (12) @(negedge CLK_50M);
    check_val("rst_mid.en_before", LCD_EN, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    m_rd_data = 8'h00;
    m_bf      = 1'b0;
    m_ac      = 7'h00;
    @(negedge CLK_50M);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    repeat (3) @(negedge CLK_50M);
    check_reset_vals("reset");
    rst_n = 1'b1;

    resp[0] = 8'h4A;
    run_op("status", 1'b0, 1'b0, 1'b0);

    resp[0] = 8'h85; resp[1] = 8'h85; resp[2] = 8'h85; resp[3] = 8'h05;
    run_op("busy_poll", 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) resp[i] = 8'h80;
    run_op("timeout", 1'b0, 1'b1, 1'b0);

    resp[0] = 8'hC3;
    run_op("data_rd", 1'b1, 1'b1, 1'b0);

    resp[0] = 8'h12;
    run_op("re_req", 1'b0, 1'b0, 1'b1);

    reset_mid_en();
    resp[0] = 8'h81; resp[1] = 8'h07;
    run_op("post_rst", 1'b0, 1'b1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      logic rs_r, pl_r;
      int   nb;
      rs_r = 1'($urandom_range(0, 1));
      pl_r = 1'($urandom_range(0, 1));
      nb   = $urandom_range(0, 9);
      for (int i = 0; i < 16; i++) begin
        if (i < nb)       resp[i] = {1'b1, 7'($urandom)};
        else if (i == nb) resp[i] = {1'b0, 7'($urandom)};
        else              resp[i] = 8'($urandom);
      end
      run_op($sformatf("rand%0d", t), rs_r, pl_r, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
